rcvbuf_fifo: RTL



---
 rtl/rcvbuf_fifo.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/rcvbuf_fifo.sv
// Oversampling serial receiver (start, DATA_BITS data LSB first, stop) feeding a
// DEPTH-entry first-word-fall-through FIFO with sticky overrun/framing flags.
module rcvbuf_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int DEPTH        = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       read,
  output logic                       ready,
  output logic [DATA_BITS-1:0]       data_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overrun,
  output logic                       frame_err,
  input  logic                       clr_err,
  input  logic                       serial_in
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam int PW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
  localparam logic [NW-1:0] DEPTH_N  = NW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAITHI,
    PUSH
  } state_t;

  state_t               state, state_nxt;
  logic                 rx_meta, rx_s;
  logic [CW-1:0]        bit_cnt, cnt_nxt;
  logic [IW-1:0]        bit_idx, idx_nxt;
  logic [DATA_BITS-1:0] shreg, sh_nxt;
  logic                 push, ferr_set;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic                 pop, wr_en, ovr_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      rx_meta <= serial_in;
      rx_s    <= rx_meta;
      state   <= state_nxt;
      bit_cnt <= cnt_nxt;
      bit_idx <= idx_nxt;
      shreg   <= sh_nxt;
    end
  end

  // Bit counter restarts at the mid-start sample, so every later sample lands mid-bit.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    idx_nxt   = bit_idx;
    sh_nxt    = shreg;
    push      = 1'b0;
    ferr_set  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      START: begin
        if (bit_cnt == HALF_M1) begin
          if (rx_s) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = DATA;
            cnt_nxt   = '0;
            idx_nxt   = '0;
          end
        end else begin
          cnt_nxt = bit_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_cnt == FULL_M1) begin
          cnt_nxt = '0;
          sh_nxt  = {rx_s, shreg[DATA_BITS-1:1]};
          if (bit_idx == LAST_IDX) state_nxt = STOP;
          else                     idx_nxt   = bit_idx + 1'b1;
        end else begin
          cnt_nxt = bit_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_cnt == FULL_M1) begin
          cnt_nxt = '0;
          if (rx_s) begin
            state_nxt = PUSH;
          end else begin
            ferr_set  = 1'b1;
            state_nxt = WAITHI;
          end
        end else begin
          cnt_nxt = bit_cnt + 1'b1;
        end
      end
      // Hold off until the line returns high so a break cannot retrigger a frame.
      WAITHI: begin
        if (rx_s) state_nxt = IDLE;
      end
      PUSH: begin
        push      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ready    = (count != '0);
  assign data_out = mem[rd_ptr];
  assign pop      = read && ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the word.
  assign wr_en    = push && ((count != DEPTH_N) || pop);
  assign ovr_set  = push && !wr_en;

  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (ovr_set)      overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
      if (ferr_set)     frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
    end
  end

endmodule
